// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline stages (fetch, decode, execute).
//  - PC_WIDTH / INSTR_WIDTH : datapath widths
//  - OPCODE_HALT            : opcode that stops instruction fetch
//  - NOP_INSTR              : all-zero instruction used to fill bubbles
//  - fetch_state_t          : fetch FSM states (RUN, HALT)
//  - pc_t / instr_t         : program counter and instruction word types
//  - opcode_of()            : extracts the 6-bit opcode field [17:12]
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_WIDTH    = 16;
    localparam int INSTR_WIDTH = 18;

    typedef logic [PC_WIDTH-1:0]    pc_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    localparam logic [5:0] OPCODE_HALT = 6'b111111;
    localparam instr_t     NOP_INSTR   = '0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Opcode lives in the top six bits of every instruction word.
    function automatic logic [5:0] opcode_of(input instr_t instr);
        return instr[INSTR_WIDTH-1:INSTR_WIDTH-6];
    endfunction

endpackage

// File: rtl/fetch_pc_select.sv
// ---------------------------------------------------------------------------
// fetch_pc_select
// Combinational next-PC priority mux and squash-request generation for the
// fetch stage. Holds no state; the PC, FSM and fetch counter live in
// fetch_stage.
//
// Ports
//  reset                  in   synchronous reset of the stage (suppresses
//                              all accept/flush outputs while high)
//  pc                     in   current program counter
//  fstall                 in   hazard-unit stall of the fetch stage
//  in_halt                in   fetch FSM currently in HALT
//  opcode_is_halt         in   the ROM word at pc carries the HALT opcode
//  ebranch_taken          in   EXECUTE resolved a taken branch
//  ebranch_target         in   branch destination
//  djump                  in   DECODE holds a jump
//  djumpaddress           in   12-bit jump field
//  dinstruction_increment in   PC+1 of the DECODE instruction
//  next_pc                out  PC value to load on the next edge
//  pc_increment           out  pc + 1, modulo 2^16
//  branch_accept          out  branch redirect taken this cycle
//  redirect               out  branch or jump redirect taken this cycle
//  halt_enter             out  RUN -> HALT transition this cycle
//  flush_fd               out  squash the FD register next edge
//  flush_de               out  squash the DE register next edge
// ---------------------------------------------------------------------------
module fetch_pc_select
    import cpu_pkg::*;
(
    input  logic        reset,
    input  pc_t         pc,
    input  logic        fstall,
    input  logic        in_halt,
    input  logic        opcode_is_halt,
    input  logic        ebranch_taken,
    input  pc_t         ebranch_target,
    input  logic        djump,
    input  logic [11:0] djumpaddress,
    input  pc_t         dinstruction_increment,
    output pc_t         next_pc,
    output pc_t         pc_increment,
    output logic        branch_accept,
    output logic        redirect,
    output logic        halt_enter,
    output logic        flush_fd,
    output logic        flush_de
);

    logic jump_accept;
    pc_t  jump_target;

    // Natural wrap at 16'hFFFF is intended.
    assign pc_increment = pc + pc_t'(1);

    // A jump keeps the upper four bits of its own PC+1 region.
    assign jump_target = {dinstruction_increment[PC_WIDTH-1:12], djumpaddress};

    // Redirect arbitration. The branch is older than anything in DECODE, so it
    // wins even over a stall and drops a simultaneous jump (wrong path). A
    // stalled jump is simply not accepted; DECODE keeps presenting it. A jump
    // cannot be legitimately seen in HALT, so it is ignored there.
    always_comb begin
        branch_accept = ebranch_taken & ~reset;
        jump_accept   = djump & ~fstall & ~ebranch_taken & ~in_halt & ~reset;
        redirect      = branch_accept | jump_accept;
        halt_enter    = ~in_halt & opcode_is_halt & ~fstall & ~redirect & ~reset;
        flush_fd      = redirect;
        flush_de      = branch_accept;
    end

    // Next-PC priority: branch, jump, stall hold, halt hold (entering or
    // already halted, so the PC freezes on the HALT address), else PC+1.
    always_comb begin
        next_pc = pc_increment;
        if (branch_accept) begin
            next_pc = ebranch_target;
        end else if (jump_accept) begin
            next_pc = jump_target;
        end else if (fstall) begin
            next_pc = pc;
        end else if (in_halt || halt_enter) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Owns the program counter, drives the asynchronous
// instruction ROM, selects the next PC (branch, jump, stall, halt, PC+1),
// raises squash requests for wrong-path fetches and stops on a HALT opcode.
// Outputs feed pipeline_register_FetchDecode.
//
// Parameters
//  RESET_PC     PC value loaded by reset
//  HALT_OPCODE  opcode that stops fetch
//
// Ports
//  clk                    in   clock, all state on posedge
//  reset                  in   synchronous, active-high
//  Fstall                 in   hold PC and instruction
//  Ebranch_taken          in   EXECUTE resolved a taken branch
//  Ebranch_target         in   branch destination PC
//  Djump                  in   DECODE holds a jump
//  Djumpaddress           in   12-bit jump field
//  Dinstruction_increment in   PC+1 of the DECODE instruction
//  Imem_address           out  ROM address (= current PC)
//  Imem_rdata             in   ROM data, combinational from Imem_address
//  Finstruction           out  fetched instruction, or NOP when suppressed
//  Finstruction_increment out  PC+1, wrapping
//  Fflush_FD              out  squash FD register next edge
//  Fflush_DE              out  squash DE register next edge
//  Fhalted                out  FSM in HALT
//  Ffetch_count           out  instructions delivered, wrapping
// ---------------------------------------------------------------------------
module fetch_stage
    import cpu_pkg::*;
#(
    parameter pc_t        RESET_PC    = 16'h0000,
    parameter logic [5:0] HALT_OPCODE = OPCODE_HALT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Fstall,
    input  logic        Ebranch_taken,
    input  pc_t         Ebranch_target,
    input  logic        Djump,
    input  logic [11:0] Djumpaddress,
    input  pc_t         Dinstruction_increment,
    output pc_t         Imem_address,
    input  instr_t      Imem_rdata,
    output instr_t      Finstruction,
    output pc_t         Finstruction_increment,
    output logic        Fflush_FD,
    output logic        Fflush_DE,
    output logic        Fhalted,
    output logic [15:0] Ffetch_count
);

    fetch_state_t state;
    fetch_state_t state_next;

    pc_t          pc;
    pc_t          next_pc;
    pc_t          pc_increment;
    logic [15:0]  fetch_count;
    logic         count_en;

    logic         in_halt;
    logic         opcode_is_halt;
    logic         branch_accept;
    logic         redirect;
    logic         halt_enter;
    logic         flush_fd;
    logic         flush_de;

    assign in_halt        = (state == HALT);
    assign opcode_is_halt = (opcode_of(Imem_rdata) == HALT_OPCODE);

    fetch_pc_select u_pc_select (
        .reset                  (reset),
        .pc                     (pc),
        .fstall                 (Fstall),
        .in_halt                (in_halt),
        .opcode_is_halt         (opcode_is_halt),
        .ebranch_taken          (Ebranch_taken),
        .ebranch_target         (Ebranch_target),
        .djump                  (Djump),
        .djumpaddress           (Djumpaddress),
        .dinstruction_increment (Dinstruction_increment),
        .next_pc                (next_pc),
        .pc_increment           (pc_increment),
        .branch_accept          (branch_accept),
        .redirect               (redirect),
        .halt_enter             (halt_enter),
        .flush_fd               (flush_fd),
        .flush_de               (flush_de)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Program counter register; all selection happens in fetch_pc_select.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Delivered-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (count_en) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

    // FSM next state and fetch outputs. The HALT word itself is delivered
    // while still in RUN; from then on a NOP is presented until a branch
    // restarts fetch. Reset overrides everything visible to the pipeline.
    always_comb begin
        state_next   = state;
        Finstruction = Imem_rdata;
        Fhalted      = 1'b0;
        count_en     = 1'b0;

        case (state)
            RUN: begin
                count_en = ~Fstall & ~redirect;
                if (halt_enter) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                Finstruction = NOP_INSTR;
                Fhalted      = 1'b1;
                if (branch_accept) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (reset) begin
            Finstruction = NOP_INSTR;
            Fhalted      = 1'b0;
            count_en     = 1'b0;
        end
    end

    assign Imem_address           = pc;
    assign Finstruction_increment = pc_increment;
    assign Fflush_FD              = flush_fd;
    assign Fflush_DE              = flush_de;
    assign Ffetch_count           = fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A small ROM model answers the DUT's
// address combinationally; a cycle-level reference model of the fetch rules
// predicts PC, halt status and fetch count, and a compare process checks all
// outputs on every falling edge. Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        Fstall;
    logic        Ebranch_taken;
    logic [15:0] Ebranch_target;
    logic        Djump;
    logic [11:0] Djumpaddress;
    logic [15:0] Dinstruction_increment;
    logic [15:0] Imem_address;
    logic [17:0] Imem_rdata;
    logic [17:0] Finstruction;
    logic [15:0] Finstruction_increment;
    logic        Fflush_FD;
    logic        Fflush_DE;
    logic        Fhalted;
    logic [15:0] Ffetch_count;

    int checks = 0;
    int errors = 0;

    // ROM contents: opcode 6'h01 with the low address bits, except one
    // optional HALT word.
    logic        rom_halt_en   = 1'b0;
    logic [15:0] rom_halt_addr = 16'h0007;

    function automatic logic [17:0] rom_word(input logic [15:0] addr);
        if (rom_halt_en && addr == rom_halt_addr) begin
            return {6'h3F, 12'h000};
        end
        return {6'h01, addr[11:0]};
    endfunction

    function automatic logic rom_is_halt(input logic [15:0] addr);
        logic [17:0] w;
        w = rom_word(addr);
        return (w[17:12] == 6'h3F);
    endfunction

    assign Imem_rdata = rom_word(Imem_address);

    fetch_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .Fstall                 (Fstall),
        .Ebranch_taken          (Ebranch_taken),
        .Ebranch_target         (Ebranch_target),
        .Djump                  (Djump),
        .Djumpaddress           (Djumpaddress),
        .Dinstruction_increment (Dinstruction_increment),
        .Imem_address           (Imem_address),
        .Imem_rdata             (Imem_rdata),
        .Finstruction           (Finstruction),
        .Finstruction_increment (Finstruction_increment),
        .Fflush_FD              (Fflush_FD),
        .Fflush_DE              (Fflush_DE),
        .Fhalted                (Fhalted),
        .Ffetch_count           (Ffetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state: what the PC, halt flag and counter must be.
    logic [15:0] m_pc;
    logic [15:0] m_count;
    logic        m_halted;
    logic        m_valid = 1'b0;

    // Advance the model by one clock according to the fetch rules.
    always @(posedge clk) begin
        if (reset) begin
            m_pc     <= 16'h0000;
            m_count  <= 16'h0000;
            m_halted <= 1'b0;
            m_valid  <= 1'b1;
        end else if (m_valid) begin
            if (Ebranch_taken) begin
                m_pc     <= Ebranch_target;
                m_halted <= 1'b0;
            end else if (Djump && !Fstall && !m_halted) begin
                m_pc <= {Dinstruction_increment[15:12], Djumpaddress};
            end else if (!Fstall && !m_halted) begin
                m_count <= m_count + 16'd1;
                if (rom_is_halt(m_pc)) begin
                    m_halted <= 1'b1;
                end else begin
                    m_pc <= m_pc + 16'd1;
                end
            end
        end
    end

    // Compare every output against the model away from the active edge.
    logic [17:0] e_instr;
    logic        e_halted;
    logic        e_ffd;
    logic        e_fde;
    logic [15:0] e_inc;

    always @(negedge clk) begin
        if (m_valid) begin
            e_inc = m_pc + 16'd1;
            if (reset) begin
                e_instr  = 18'h0;
                e_halted = 1'b0;
                e_ffd    = 1'b0;
                e_fde    = 1'b0;
            end else begin
                e_halted = m_halted;
                e_instr  = m_halted ? 18'h0 : rom_word(m_pc);
                e_fde    = Ebranch_taken;
                e_ffd    = Ebranch_taken | (Djump & ~Fstall & ~m_halted);
            end
            check_output("model_addr",  {16'h0, Imem_address},           {16'h0, m_pc});
            check_output("model_inc",   {16'h0, Finstruction_increment}, {16'h0, e_inc});
            check_output("model_instr", {14'h0, Finstruction},           {14'h0, e_instr});
            check_output("model_halt",  {31'h0, Fhalted},                {31'h0, e_halted});
            check_output("model_ffd",   {31'h0, Fflush_FD},              {31'h0, e_ffd});
            check_output("model_fde",   {31'h0, Fflush_DE},              {31'h0, e_fde});
            check_output("model_count", {16'h0, Ffetch_count},           {16'h0, m_count});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic stall, input logic br, input logic [15:0] tgt,
                                  input logic dj, input logic [11:0] da, input logic [15:0] dinc);
        Fstall                 = stall;
        Ebranch_taken          = br;
        Ebranch_target         = tgt;
        Djump                  = dj;
        Djumpaddress           = da;
        Dinstruction_increment = dinc;
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 16'h0, 1'b0, 12'h0, 16'h0);
    endtask

    initial begin
        // 1: reset, then linear fetch
        reset = 1'b1;
        idle();
        repeat (3) tick();
        check_output("rst_instr", {14'h0, Finstruction}, 32'h0);
        check_output("rst_halted", {31'h0, Fhalted}, 32'h0);
        check_output("rst_addr", {16'h0, Imem_address}, 32'h0);
        reset = 1'b0;
        #1;
        check_output("lin_addr0", {16'h0, Imem_address}, 32'h0);
        check_output("lin_inc0", {16'h0, Finstruction_increment}, 32'h1);
        check_output("lin_cnt0", {16'h0, Ffetch_count}, 32'h0);
        check_output("lin_instr0", {14'h0, Finstruction}, 32'h01000);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_output("lin_addr", {16'h0, Imem_address}, i);
            check_output("lin_inc", {16'h0, Finstruction_increment}, i + 1);
            check_output("lin_cnt", {16'h0, Ffetch_count}, i);
        end
        tick();

        // 2: stall three cycles at PC 4
        apply_stimulus(1'b1, 1'b0, 16'h0, 1'b0, 12'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            check_output("stall_addr", {16'h0, Imem_address}, 32'h4);
            check_output("stall_instr", {14'h0, Finstruction}, 32'h01004);
            check_output("stall_cnt", {16'h0, Ffetch_count}, 32'h4);
            if (i < 2) tick();
        end
        idle();
        check_output("stall_rel_addr", {16'h0, Imem_address}, 32'h4);
        tick();
        check_output("resume_addr", {16'h0, Imem_address}, 32'h5);
        check_output("resume_cnt", {16'h0, Ffetch_count}, 32'h5);

        // 3: jump from 0x1234
        apply_stimulus(1'b0, 1'b1, 16'h1234, 1'b0, 12'h0, 16'h0);
        tick();
        idle();
        check_output("br_addr", {16'h0, Imem_address}, 32'h1234);
        check_output("br_cnt", {16'h0, Ffetch_count}, 32'h5);
        apply_stimulus(1'b0, 1'b0, 16'h0, 1'b1, 12'hABC, 16'h1230);
        check_output("jmp_ffd", {31'h0, Fflush_FD}, 32'h1);
        check_output("jmp_fde", {31'h0, Fflush_DE}, 32'h0);
        tick();
        idle();
        check_output("jmp_addr", {16'h0, Imem_address}, 32'h1ABC);
        // stalled jump is ignored, then taken once the stall drops
        apply_stimulus(1'b1, 1'b0, 16'h0, 1'b1, 12'h100, 16'h1ABD);
        check_output("sjmp_ffd", {31'h0, Fflush_FD}, 32'h0);
        tick();
        check_output("sjmp_hold", {16'h0, Imem_address}, 32'h1ABC);
        apply_stimulus(1'b0, 1'b0, 16'h0, 1'b1, 12'h100, 16'h1ABD);
        check_output("sjmp_ffd2", {31'h0, Fflush_FD}, 32'h1);
        tick();
        idle();
        check_output("sjmp_addr", {16'h0, Imem_address}, 32'h1100);

        // 4: branch beats stall and jump
        apply_stimulus(1'b1, 1'b1, 16'h0040, 1'b1, 12'hABC, 16'h1230);
        check_output("bsj_ffd", {31'h0, Fflush_FD}, 32'h1);
        check_output("bsj_fde", {31'h0, Fflush_DE}, 32'h1);
        tick();
        idle();
        check_output("bsj_addr", {16'h0, Imem_address}, 32'h0040);
        check_output("bsj_cnt", {16'h0, Ffetch_count}, 32'h5);

        // 5: HALT at address 7
        rom_halt_en = 1'b1;
        apply_stimulus(1'b0, 1'b1, 16'h0005, 1'b0, 12'h0, 16'h0);
        tick();
        idle();
        tick();
        tick();
        check_output("h_addr7", {16'h0, Imem_address}, 32'h7);
        check_output("h_word", {14'h0, Finstruction}, 32'h3F000);
        check_output("h_pre", {31'h0, Fhalted}, 32'h0);
        check_output("h_cnt7", {16'h0, Ffetch_count}, 32'h7);
        tick();
        check_output("h_halted", {31'h0, Fhalted}, 32'h1);
        check_output("h_nop", {14'h0, Finstruction}, 32'h0);
        check_output("h_hold", {16'h0, Imem_address}, 32'h7);
        check_output("h_cnt8", {16'h0, Ffetch_count}, 32'h8);
        tick();
        check_output("h_hold2", {16'h0, Imem_address}, 32'h7);
        check_output("h_cnt_frz", {16'h0, Ffetch_count}, 32'h8);
        apply_stimulus(1'b0, 1'b1, 16'h0010, 1'b0, 12'h0, 16'h0);
        check_output("h_br_ffd", {31'h0, Fflush_FD}, 32'h1);
        check_output("h_br_fde", {31'h0, Fflush_DE}, 32'h1);
        tick();
        idle();
        check_output("h_exit_addr", {16'h0, Imem_address}, 32'h0010);
        check_output("h_exit_halt", {31'h0, Fhalted}, 32'h0);
        tick();
        check_output("h_run_cnt", {16'h0, Ffetch_count}, 32'h9);
        apply_stimulus(1'b0, 1'b1, 16'h0007, 1'b0, 12'h0, 16'h0);
        tick();
        idle();
        tick();
        check_output("h2_halted", {31'h0, Fhalted}, 32'h1);
        apply_stimulus(1'b0, 1'b0, 16'h0, 1'b1, 12'h123, 16'h2000);
        check_output("h2_jmp_ffd", {31'h0, Fflush_FD}, 32'h0);
        tick();
        idle();
        check_output("h2_jmp_hold", {16'h0, Imem_address}, 32'h7);
        reset = 1'b1;
        #1;
        check_output("h2_rst_halt", {31'h0, Fhalted}, 32'h0);
        check_output("h2_rst_instr", {14'h0, Finstruction}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check_output("h2_rst_addr", {16'h0, Imem_address}, 32'h0);
        check_output("h2_rst_cnt", {16'h0, Ffetch_count}, 32'h0);
        check_output("h2_rst_run", {31'h0, Fhalted}, 32'h0);

        // 6: PC wrap at 16'hFFFF
        rom_halt_en = 1'b0;
        apply_stimulus(1'b0, 1'b1, 16'hFFFE, 1'b0, 12'h0, 16'h0);
        tick();
        idle();
        check_output("w_addr_fffe", {16'h0, Imem_address}, 32'hFFFE);
        check_output("w_inc_ffff", {16'h0, Finstruction_increment}, 32'hFFFF);
        tick();
        check_output("w_addr_ffff", {16'h0, Imem_address}, 32'hFFFF);
        check_output("w_inc_0000", {16'h0, Finstruction_increment}, 32'h0000);
        tick();
        check_output("w_addr_0000", {16'h0, Imem_address}, 32'h0000);
        check_output("w_inc_0001", {16'h0, Finstruction_increment}, 32'h0001);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
